hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDRESS_LENGTH, default 5, register address width.
REQ-002 SHALL have parameter STAT_WIDTH, default 16, width of stall_cnt.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports id_valid, id_ra_used, id_rb_used, id_wr_en, id_is_load  input  1 each  ID-stage instruction qualifiers.
REQ-006 SHALL have ports id_ra, id_rb, id_rd  input  REG_ADDRESS_LENGTH each  ID-stage source and destination addresses.
REQ-007 SHALL have port mem_busy  input  1  memory not ready; freeze whole pipeline.
REQ-008 SHALL have port stall_if_id  output  1  hold PC and IF/ID register.
REQ-009 SHALL have port bubble_ex  output  1  load NOP into ID/EX register.
REQ-010 SHALL have ports fwd_sel_a, fwd_sel_b  output  2 each  EX operand select: 0=regfile, 1=EX/MEM, 2=MEM/WB; 3 never driven.
REQ-011 SHALL have port stall_cnt  output  STAT_WIDTH  load-use bubble count; present only with HDU_STATS_EN.

Function
REQ-012 SHALL keep shadow entries EX, MEM, WB, each holding {valid, rd, wr_en, is_load}, mirroring the in-flight instruction of that stage.
REQ-013 SHALL, on a non-frozen edge: EX<=ID instruction (valid=id_valid), or an invalid entry when bubble_ex=1; MEM<=EX; WB<=MEM.
REQ-014 SHALL define a source match as: source used, producer valid, producer wr_en, and address equality; all addresses, including 0, are ordinary registers.
REQ-015 SHALL assert load-use hazard (combinational) when id_valid and a used source matches EX with EX.is_load=1.
REQ-016 SHALL run FSM states RUN, LU_STALL, FREEZE.
REQ-017 SHALL, in RUN: go to FREEZE if mem_busy; else to LU_STALL if load-use hazard; else stay in RUN.
REQ-018 SHALL, in LU_STALL: drive stall_if_id=1, bubble_ex=1 for exactly one cycle; go to FREEZE if mem_busy, else to RUN.
REQ-019 SHALL, in FREEZE: drive stall_if_id=1, bubble_ex=0; hold all shadow entries, fwd_sel, and stall_cnt; return to RUN when mem_busy=0.
REQ-020 SHALL drive the load-use stall combinationally in the hazard cycle (stall_if_id=bubble_ex=1 in RUN when a hazard exists and mem_busy=0), so the bubble enters EX on that edge; LU_STALL records that the bubble was issued and blocks a second bubble for the same pair.
REQ-021 SHALL give mem_busy priority over load-use; a hazard pending at freeze is re-evaluated on the return to RUN.
REQ-022 SHALL register fwd_sel_a/b on each non-frozen edge, so they are valid during the consumer's EX cycle: 1 if the source matches EX (non-load), else 2 if it matches MEM, else 0; EX has priority over MEM when both match.
REQ-023 SHALL register fwd_sel=0 when a bubble is inserted or id_valid=0.
REQ-024 SHALL not forward from WB; the register file is write-through.

Reset
REQ-025 SHALL, on reset assertion: invalidate all shadow entries, set FSM=RUN, and clear fwd_sel_a/b=0 and stall_cnt=0 immediately; stall_if_id=bubble_ex=0 unless a hazard exists, which it cannot after reset.
REQ-026 SHALL discard any in-progress stall or freeze when reset is asserted mid-operation; no stall persists after release.

Configuration
REQ-027 SHALL, with HDU_STATS_EN defined, count each load-use bubble in stall_cnt, saturating at all-ones.
REQ-028 SHALL, without HDU_STATS_EN, omit stall_cnt and its register; all other behaviour is identical.

Structure
REQ-029 SHALL take the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB encodings, FSM state type, and shadow-entry struct from shared package hdu_pkg.
REQ-030 SHALL instantiate sub-module hazard_cmp (one source vs. one entry -> match) for each source-entry pair.

Verification
REQ-031 SHALL verify ADD r3 then ADD r4,r3,r5 back-to-back -> no stall; consumer EX cycle fwd_sel_a=1.
REQ-032 SHALL verify ADD r3, NOP, SUB r6,r7,r3 -> fwd_sel_b=2, no stall.
REQ-033 SHALL verify LD r8 then ADD r9,r8,r8 -> one cycle stall_if_id=bubble_ex=1; then fwd_sel_a=fwd_sel_b=2; stall_cnt=1.
REQ-034 SHALL verify mem_busy=1 for 3 cycles during a load-use hazard -> 3 freeze cycles with bubble_ex=0, then exactly one bubble; stall_cnt increments once.
REQ-035 SHALL verify reset asserted in LU_STALL -> outputs 0 in the same cycle; the first instruction after release sees fwd_sel=0.
REQ-036 SHALL verify r0 producer with id_wr_en=0 -> no forward; with wr_en=1 -> fwd_sel_a=1.

Source files
------------

// File: rtl/hdu_pkg.sv
// Shared types for the hazard detection unit: forwarding encodings, FSM state
// and the per-stage shadow entry tracked for EX, MEM and WB.
package hdu_pkg;

  // Shadow entries store addresses zero-extended to this width.
  localparam int HDU_ADDR_MAX = 16;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_STALL,
    ST_FREEZE
  } hdu_state_t;

  typedef struct packed {
    logic                    valid;
    logic [HDU_ADDR_MAX-1:0] rd;
    logic                    wr_en;
    logic                    is_load;
  } shadow_entry_t;

  function automatic shadow_entry_t make_entry(
    input logic                    valid,
    input logic [HDU_ADDR_MAX-1:0] rd,
    input logic                    wr_en,
    input logic                    is_load
  );
    shadow_entry_t e;
    e.valid   = valid;
    e.rd      = rd;
    e.wr_en   = wr_en;
    e.is_load = is_load;
    return e;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID-stage source operand against one in-flight shadow entry.
// Register 0 is an ordinary register here, so no special case for address 0.
module hazard_cmp
  import hdu_pkg::*;
#(
  parameter int REG_ADDRESS_LENGTH = 5
) (
  input  logic                          used,
  input  logic [REG_ADDRESS_LENGTH-1:0] addr,
  input  shadow_entry_t                 entry,
  output logic                          match
);

  assign match = used && entry.valid && entry.wr_en &&
                 (entry.rd == HDU_ADDR_MAX'(addr));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, memory freeze and EX operand forwarding.
// Define HDU_STATS_EN to add the saturating load-use bubble counter stall_cnt.
module hazard_ctrl
  import hdu_pkg::*;
#(
  parameter int REG_ADDRESS_LENGTH = 5,
  parameter int STAT_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic                          id_ra_used,
  input  logic                          id_rb_used,
  input  logic                          id_wr_en,
  input  logic                          id_is_load,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_ra,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rb,
  input  logic [REG_ADDRESS_LENGTH-1:0] id_rd,
  input  logic                          mem_busy,
  output logic                          stall_if_id,
  output logic                          bubble_ex,
  output logic [1:0]                    fwd_sel_a,
  output logic [1:0]                    fwd_sel_b
`ifdef HDU_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]         stall_cnt
`endif
);

  hdu_state_t    state_reg;
  shadow_entry_t ex_reg, mem_reg, wb_reg;
  shadow_entry_t id_entry;
  shadow_entry_t cmp_entry [2];
  logic [1:0]    match_a, match_b;
  logic [1:0]    fwd_a_next, fwd_b_next;
  logic          load_use, frozen, issue_bubble;

  assign cmp_entry[0] = ex_reg;
  assign cmp_entry[1] = mem_reg;

  // Index 0 compares against EX, index 1 against MEM; WB is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      hazard_cmp #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH)) u_cmp_a (
        .used  (id_ra_used),
        .addr  (id_ra),
        .entry (cmp_entry[gi]),
        .match (match_a[gi])
      );
      hazard_cmp #(.REG_ADDRESS_LENGTH(REG_ADDRESS_LENGTH)) u_cmp_b (
        .used  (id_rb_used),
        .addr  (id_rb),
        .entry (cmp_entry[gi]),
        .match (match_b[gi])
      );
    end
  endgenerate

  assign id_entry     = make_entry(id_valid, HDU_ADDR_MAX'(id_rd), id_wr_en, id_is_load);
  assign load_use     = id_valid && ex_reg.is_load && (match_a[0] || match_b[0]);
  assign frozen       = mem_busy || (state_reg == ST_FREEZE);
  // The bubble is issued in the hazard cycle itself; LU_STALL only records it.
  assign issue_bubble = (state_reg == ST_RUN) && load_use && !mem_busy;
  assign bubble_ex    = issue_bubble;
  assign stall_if_id  = issue_bubble || (state_reg == ST_FREEZE);

  always_comb begin
    fwd_a_next = FWD_REGFILE;
    fwd_b_next = FWD_REGFILE;
    if (id_valid && !issue_bubble) begin
      if (match_a[0] && !ex_reg.is_load) fwd_a_next = FWD_EXMEM;
      else if (match_a[1])               fwd_a_next = FWD_MEMWB;
      if (match_b[0] && !ex_reg.is_load) fwd_b_next = FWD_EXMEM;
      else if (match_b[1])               fwd_b_next = FWD_MEMWB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:      state_reg <= mem_busy ? ST_FREEZE : (load_use ? ST_LU_STALL : ST_RUN);
        ST_LU_STALL: state_reg <= mem_busy ? ST_FREEZE : ST_RUN;
        ST_FREEZE:   state_reg <= mem_busy ? ST_FREEZE : ST_RUN;
        default:     state_reg <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
      fwd_sel_a <= FWD_REGFILE;
      fwd_sel_b <= FWD_REGFILE;
    end else if (!frozen) begin
      ex_reg    <= issue_bubble ? '0 : id_entry;
      mem_reg   <= ex_reg;
      wb_reg    <= mem_reg;
      fwd_sel_a <= fwd_a_next;
      fwd_sel_b <= fwd_b_next;
    end
  end

`ifdef HDU_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (issue_bubble && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
